buzzer_sequencer: RTL

Parametrised audio sequencer that drives the board's piezo buzzer pin. It replaces the single fixed 1 kHz alarm tone with three prioritised sound modes:
- a cadenced alarm (beep/pause),
- a two-tone hourly chime,
- a short key click.

It sits between the clock controller and the key/debounce logic on one side and the physical buzzer pin on the other. Tone pitch, cadence and click length are set by parameters.

---
 rtl/buzzer_if.sv | 19 +
 rtl/buzzer_sequencer.sv | 91 +++++++++
 2 files changed

// File: rtl/buzzer_if.sv
// buzzer_if: request/status bundle between the key and clock logic and the buzzer sequencer
//   alarm_on  level, alarm requested while high
//   chime_req one-cycle pulse, request an hourly chime
//   click_req one-cycle pulse, request a key click
//   mute      level, silences everything while high
//   beep      registered buzzer drive
//   busy      high whenever the sequencer is not idle
//   mode      0 idle, 1 alarm, 2 chime, 3 click
interface buzzer_if;
    logic       alarm_on;
    logic       chime_req;
    logic       click_req;
    logic       mute;
    logic       beep;
    logic       busy;
    logic [1:0] mode;
    modport master (output alarm_on, chime_req, click_req, mute, input beep, busy, mode);
    modport slave (input alarm_on, chime_req, click_req, mute, output beep, busy, mode);
endinterface

// File: rtl/buzzer_sequencer.sv
// buzzer_sequencer: prioritised alarm / chime / click tone sequencer for the piezo pin
//   clk, rst   system clock, synchronous active-high reset
//   bus        buzzer_if.slave: alarm_on, chime_req, click_req, mute in; beep, busy, mode out
//   BUZZER_CHIME_EN builds the two-tone chime; without it chime_req is ignored
module buzzer_sequencer #(
    parameter int TONE_HI_DIV = 25000,
    parameter int TONE_LO_DIV = 31250,
    parameter int BEAT_CYC    = 12500000,
    parameter int CLICK_CYC   = 1000000,
    parameter int DIV_W       = 16,
    parameter int BEAT_W      = 24
) (
    input logic     clk,
    input logic     rst,
    buzzer_if.slave bus
);
`ifdef BUZZER_CHIME_EN
    typedef enum logic [2:0] {IDLE, AL_ON, AL_OFF, CH_HI, CH_LO, CLICK} state_t;
`else
    typedef enum logic [2:0] {IDLE, AL_ON, AL_OFF, CLICK} state_t;
`endif
    state_t state, nxt;
    logic [DIV_W-1:0]  tone_cnt, tone_lim;
    logic [BEAT_W-1:0] beat_cnt, beat_lim;
    logic beep, restart, tone_st, tone_end, beat_end;
    always_comb begin
        tone_lim = DIV_W'(TONE_HI_DIV - 1);
`ifdef BUZZER_CHIME_EN
        if (state == CH_LO) tone_lim = DIV_W'(TONE_LO_DIV - 1);
`endif
        beat_lim = (state == CLICK) ? BEAT_W'(CLICK_CYC - 1) : BEAT_W'(BEAT_CYC - 1);
        tone_end = tone_cnt == tone_lim;
        beat_end = beat_cnt == beat_lim;
        nxt      = state;
        restart  = 1'b0;
        if (bus.mute)
            nxt = IDLE;
        else if (bus.alarm_on)
            nxt = (state == AL_ON)  ? (beat_end ? AL_OFF : AL_ON) :
                  (state == AL_OFF) ? (beat_end ? AL_ON : AL_OFF) : AL_ON;
        else if (state == AL_ON || state == AL_OFF)
            nxt = IDLE;
`ifdef BUZZER_CHIME_EN
        else if (bus.chime_req && (state == IDLE || state == CLICK))
            nxt = CH_HI;
`endif
        else if (bus.click_req && (state == IDLE || state == CLICK)) begin
            nxt     = CLICK;
            restart = state == CLICK;
        end
`ifdef BUZZER_CHIME_EN
        else if (beat_end && state == CH_HI)
            nxt = CH_LO;
`endif
        else if (beat_end && state != IDLE)
            nxt = IDLE;
`ifdef BUZZER_CHIME_EN
        tone_st = nxt inside {AL_ON, CH_HI, CH_LO, CLICK};
`else
        tone_st = nxt inside {AL_ON, CLICK};
`endif
    end
    // Any entry (including a click restart) starts the tone high with fresh counters;
    // otherwise nxt equals state, so tone_st also describes the current state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            tone_cnt <= '0;
            beat_cnt <= '0;
            beep     <= 1'b0;
        end else begin
            state <= nxt;
            if (nxt != state || restart) begin
                tone_cnt <= '0;
                beat_cnt <= '0;
                beep     <= tone_st;
            end else if (state != IDLE) begin
                beat_cnt <= beat_cnt + BEAT_W'(1);
                if (tone_st) begin
                    tone_cnt <= tone_end ? '0 : tone_cnt + DIV_W'(1);
                    beep     <= beep ^ tone_end;
                end
            end
        end
    end
    assign bus.beep = beep;
    assign bus.busy = state != IDLE;
    assign bus.mode = (state == CLICK) ? 2'd3 :
                      (state == AL_ON || state == AL_OFF) ? 2'd1 :
                      (state == IDLE) ? 2'd0 : 2'd2;
endmodule
